// File: rtl/serial_in_parallel_out_sipo_32_bit_framed.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_in_parallel_out_sipo_32_bit_framed                                  |
// | Framed serial-to-parallel receiver with valid/ready hold register.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module serial_in_parallel_out_sipo_32_bit_framed #(
  parameter int DATA_WIDTH = 32,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                          Clk_In,
  input  logic                          Reset_In,
  input  logic                          Serial_Data_In,
  input  logic                          Serial_Valid_In,
  input  logic                          Frame_Start_In,
  input  logic                          Data_Ready_In,
  input  logic                          Overrun_Clear_In,
  output logic [DATA_WIDTH-1:0]         Parallel_Data_Out,
  output logic                          Data_Valid_Out,
  output logic                          Overrun_Out,
  output logic                          Busy_Out,
  output logic [$clog2(DATA_WIDTH)-1:0] Bit_Count_Out
);

  localparam int          c_CNT_W   = $clog2(DATA_WIDTH);
  localparam logic [0:0]  c_IDLE    = 1'b0;
  localparam logic [0:0]  c_RECEIVE = 1'b1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [c_CNT_W-1:0]    count_q, count_d;
  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;

  logic [DATA_WIDTH-1:0] w_shifted;
  logic [DATA_WIDTH-1:0] w_first;
  logic                  w_transfer;
  logic                  w_complete;
  logic                  w_overrun_set;

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] sr,
                                                     input logic b);
    if (MSB_FIRST) return {sr[DATA_WIDTH-2:0], b};
    else           return {b, sr[DATA_WIDTH-1:1]};
  endfunction

  assign w_shifted  = shift_in(sr_q, Serial_Data_In);
  assign w_first    = shift_in('0, Serial_Data_In);
  assign w_transfer = valid_q & Data_Ready_In;

  always_comb begin
    sr_d          = sr_q;
    count_d       = count_q;
    state_d       = state_q;
    data_d        = data_q;
    valid_d       = valid_q;
    w_complete    = 1'b0;
    w_overrun_set = 1'b0;

    // Frame start dominates: it drops the partial word, even one bit short of completion.
    if (Frame_Start_In) begin
      sr_d    = Serial_Valid_In ? w_first : '0;
      count_d = Serial_Valid_In ? c_CNT_W'(1) : '0;
      state_d = Serial_Valid_In ? c_RECEIVE : c_IDLE;
    end else if (Serial_Valid_In) begin
      sr_d    = w_shifted;
      count_d = count_q + c_CNT_W'(1);
      case (state_q)
        c_IDLE:    state_d = c_RECEIVE;
        c_RECEIVE: begin
          if (count_q == c_LAST) begin
            state_d    = c_IDLE;
            count_d    = '0;
            w_complete = 1'b1;
          end
        end
        default:   state_d = c_IDLE;
      endcase
    end

    if (w_complete) begin
      if (!valid_q || w_transfer) begin
        data_d  = w_shifted;
        valid_d = 1'b1;
      end else begin
        w_overrun_set = 1'b1;
      end
    end else if (w_transfer) begin
      valid_d = 1'b0;
    end

    overrun_d = w_overrun_set | (overrun_q & ~Overrun_Clear_In);
  end

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      sr_q      <= '0;
      count_q   <= '0;
      state_q   <= c_IDLE;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign Parallel_Data_Out = data_q;
  assign Data_Valid_Out    = valid_q;
  assign Overrun_Out       = overrun_q;
  assign Busy_Out          = (count_q != '0);
  assign Bit_Count_Out     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_in_parallel_out_sipo_32_bit_framed.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_serial_in_parallel_out_sipo_32_bit_framed                               |
// | Randomized and directed bench with a queue-based reference model.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_serial_in_parallel_out_sipo_32_bit_framed;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sd, sv, fs, rdy, clr;
  logic [31:0] pdo;
  logic        dvo, ovo, bso;
  logic [4:0]  bco;

  int checks   = 0;
  int failures = 0;

  bit          mq[$];
  logic [31:0] m_data;
  bit          m_valid, m_ovr;

  always #5 clk = ~clk;

  serial_in_parallel_out_sipo_32_bit_framed #(.DATA_WIDTH(32), .MSB_FIRST(1'b1)) dut (
    .Clk_In            (clk),
    .Reset_In          (rst_n),
    .Serial_Data_In    (sd),
    .Serial_Valid_In   (sv),
    .Frame_Start_In    (fs),
    .Data_Ready_In     (rdy),
    .Overrun_Clear_In  (clr),
    .Parallel_Data_Out (pdo),
    .Data_Valid_Out    (dvo),
    .Overrun_Out       (ovo),
    .Busy_Out          (bso),
    .Bit_Count_Out     (bco)
  );

  task automatic model_reset();
    mq.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model on the edge, return 1 time unit after it.
  task automatic step(input bit d, input bit v, input bit f, input bit r, input bit c);
    bit          xfer, done, set;
    logic [31:0] word;
    sd = d; sv = v; fs = f; rdy = r; clr = c;
    @(posedge clk);
    xfer = m_valid && r;
    done = 1'b0;
    set  = 1'b0;
    word = '0;
    if (f) begin
      mq.delete();
      if (v) mq.push_back(d);
    end else if (v) begin
      mq.push_back(d);
      if (mq.size() == 32) begin
        for (int i = 0; i < 32; i++) word[31-i] = mq[i];
        mq.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (!m_valid || xfer) begin
        m_data  = word;
        m_valid = 1'b1;
      end else begin
        set = 1'b1;
      end
    end else if (xfer) begin
      m_valid = 1'b0;
    end
    m_ovr = set ? 1'b1 : (c ? 1'b0 : m_ovr);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit ready_last, input bit clr_last);
    for (int i = 0; i < 32; i++)
      step(w[31-i], 1'b1, 1'b0, (i == 31) ? ready_last : 1'b0, (i == 31) ? clr_last : 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sd = 0; sv = 0; fs = 0; rdy = 0; clr = 0;
    model_reset();
    repeat (6) begin
      sd = 1'($urandom); sv = 1'b1; rdy = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({pdo, dvo, ovo, bso, bco} !== 40'h0) begin
        failures++;
        $display("FAIL reset_hold: got pdo=%h dvo=%b ovo=%b bso=%b bco=%0d, want all zero",
                 pdo, dvo, ovo, bso, bco);
      end
    end
    rst_n = 1'b1;
    step(1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bco !== 5'd1 || bso !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: got bco=%0d bso=%b, want 1 1", bco, bso);
    end
  endtask

  task automatic test_loopback();
    logic [31:0] w = 32'hA5A5_1234;
    step(w[31], 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 32; i++) begin
      step(w[31-i], 1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 30) begin
        checks++;
        if (dvo !== 1'b0 || bco !== 5'd31) begin
          failures++;
          $display("FAIL loopback_pre: got dvo=%b bco=%0d, want 0 31", dvo, bco);
        end
      end
    end
    checks++;
    if (pdo !== w || dvo !== 1'b1 || bco !== 5'd0 || bso !== 1'b0) begin
      failures++;
      $display("FAIL loopback_word: got pdo=%h dvo=%b bco=%0d bso=%b, want %h 1 0 0",
               pdo, dvo, bco, bso, w);
    end
    repeat (3) step(1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pdo !== w || dvo !== 1'b1) begin
      failures++;
      $display("FAIL loopback_hold: got pdo=%h dvo=%b, want %h 1", pdo, dvo, w);
    end
  endtask

  task automatic test_backpressure();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dvo !== 1'b0) begin
      failures++;
      $display("FAIL bp_consume: got dvo=%b, want 0", dvo);
    end
    send_word(32'hDEAD_BEEF, 1'b0, 1'b0);
    send_word(32'h0000_0001, 1'b0, 1'b0);
    checks++;
    if (pdo !== 32'hDEAD_BEEF || dvo !== 1'b1 || ovo !== 1'b1) begin
      failures++;
      $display("FAIL bp_overrun: got pdo=%h dvo=%b ovo=%b, want deadbeef 1 1", pdo, dvo, ovo);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ovo !== 1'b0) begin
      failures++;
      $display("FAIL bp_clear: got ovo=%b, want 0", ovo);
    end
    send_word(32'h1234_5678, 1'b0, 1'b1);
    checks++;
    if (ovo !== 1'b1 || pdo !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL bp_set_wins: got ovo=%b pdo=%h, want 1 deadbeef", ovo, pdo);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midword();
    repeat (7) step(1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({pdo, dvo, ovo, bso, bco} !== 40'h0) begin
      failures++;
      $display("FAIL reset_async: got pdo=%h dvo=%b ovo=%b bso=%b bco=%0d, want all zero",
               pdo, dvo, ovo, bso, bco);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_simultaneous();
    logic [31:0] first = $urandom;
    send_word(first, 1'b0, 1'b0);
    send_word(32'h1357_9BDF, 1'b1, 1'b0);
    checks++;
    if (pdo !== 32'h1357_9BDF || dvo !== 1'b1 || ovo !== 1'b0) begin
      failures++;
      $display("FAIL simultaneous: got pdo=%h dvo=%b ovo=%b, want 13579bdf 1 0", pdo, dvo, ovo);
    end
  endtask

  task automatic test_gapped();
    logic [31:0] w = 32'hF0F0_0F0F;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      if (i % 2 == 0) begin
        step(1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bco !== 5'(i / 2)) begin
          failures++;
          $display("FAIL gapped_hold[%0d]: got bco=%0d, want %0d", i, bco, i / 2);
        end
      end else begin
        step(w[31-i/2], 1'b1, 1'b0, 1'b0, 1'b0);
      end
    end
    checks++;
    if (pdo !== w || dvo !== 1'b1 || bco !== 5'd0) begin
      failures++;
      $display("FAIL gapped_word: got pdo=%h dvo=%b bco=%0d, want %h 1 0", pdo, dvo, bco, w);
    end
  endtask

  task automatic test_reframe();
    logic [31:0] w = 32'h8000_0001;
    int          early = 0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) step(1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    step(w[31], 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bco !== 5'd1 || dvo !== 1'b0) begin
      failures++;
      $display("FAIL reframe_start: got bco=%0d dvo=%b, want 1 0", bco, dvo);
    end
    for (int i = 1; i < 32; i++) begin
      step(w[31-i], 1'b1, 1'b0, 1'b0, 1'b0);
      if (i < 31 && dvo !== 1'b0) early++;
    end
    checks++;
    if (early != 0 || pdo !== w || dvo !== 1'b1) begin
      failures++;
      $display("FAIL reframe_word: got pdo=%h dvo=%b early_valids=%0d, want %h 1 0",
               pdo, dvo, early, w);
    end
    for (int i = 0; i < 31; i++) step(1'($urandom), 1'b1, 1'b0, (i == 0), 1'b0);
    step(1'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (dvo !== 1'b0 || bco !== 5'd0 || pdo !== w) begin
      failures++;
      $display("FAIL reframe_at_last: got dvo=%b bco=%0d pdo=%h, want 0 0 %h", dvo, bco, pdo, w);
    end
  endtask

  task automatic test_random();
    logic [39:0] exp;
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0));
      exp = {m_data, m_valid, m_ovr, (mq.size() != 0), 5'(mq.size())};
      checks++;
      if ({pdo, dvo, ovo, bso, bco} !== exp) begin
        failures++;
        $display("FAIL random[%0d]: got pdo=%h dvo=%b ovo=%b bso=%b bco=%0d, want %h",
                 n, pdo, dvo, ovo, bso, bco, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_backpressure();
    test_reset_midword();
    test_simultaneous();
    test_gapped();
    test_reframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
